// File: rtl/pipe_issue.sv
// Instruction-issue stage: FIFO-buffered 24-bit words, combinational head decode,
// RAW interlock against the last two issues, registered outputs with NOP bubbles.
module pipe_issue #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] NOP_REG  = 4'd15,
    parameter logic [7:0] NOP_ADDR = 8'hFF
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [23:0]                in_instr,
    output logic                       in_ready,
    input  logic                       run,
    output logic [3:0]                 rs1,
    output logic [3:0]                 rs2,
    output logic [3:0]                 rd,
    output logic [3:0]                 func,
    output logic [7:0]                 addr,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                issue_cnt,
    output logic [15:0]                stall_cnt,
    output logic                       err_illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] NOP_FUNC = 4'd3;

    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;

    logic          r_h0_valid;
    logic [3:0]    r_h0_rd;
    logic          r_h1_valid;
    logic [3:0]    r_h1_rd;

    logic [3:0]    r_rs1;
    logic [3:0]    r_rs2;
    logic [3:0]    r_rd;
    logic [3:0]    r_func;
    logic [7:0]    r_addr;
    logic          r_issue_valid;
    logic [15:0]   r_issue_cnt;
    logic [15:0]   r_stall_cnt;
    logic          r_err_illegal;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_active;
    logic          w_hazard;
    logic          w_illegal;
    logic          w_use1;
    logic          w_use2;
    logic [23:0]   w_head;
    logic [3:0]    w_func;
    logic [3:0]    w_rd;
    logic [3:0]    w_rs1;
    logic [3:0]    w_rs2;
    logic [7:0]    w_addr;
    logic          w_hit1;
    logic          w_hit2;

    assign w_full   = (r_level == (AW+1)'(DEPTH));
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rptr];
    assign w_func   = w_head[23:20];
    assign w_rd     = w_head[19:16];
    assign w_rs1    = w_head[15:12];
    assign w_rs2    = w_head[11:8];
    assign w_addr   = w_head[7:0];

    // Which source fields a func actually reads; illegal funcs read neither.
    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        case (w_func)
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            4'd3, 4'd8, 4'd10, 4'd11: w_use1 = 1'b1;
            4'd4, 4'd9:               w_use2 = 1'b1;
            default: ;
        endcase
    end

    assign w_illegal = (w_func >= 4'd12);
    assign w_hit1    = (r_h0_valid && w_rs1 == r_h0_rd) || (r_h1_valid && w_rs1 == r_h1_rd);
    assign w_hit2    = (r_h0_valid && w_rs2 == r_h0_rd) || (r_h1_valid && w_rs2 == r_h1_rd);
    assign w_hazard  = (w_use1 && w_hit1) || (w_use2 && w_hit2);
    assign w_active  = run && (r_level != '0);
    assign w_pop     = w_active && !w_hazard;
    assign w_issue   = w_pop && !w_illegal;

    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_instr;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // History shifts every cycle so hazards drain even while issue is frozen.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_h0_valid <= 1'b0;
            r_h0_rd    <= '0;
            r_h1_valid <= 1'b0;
            r_h1_rd    <= '0;
        end else begin
            r_h1_valid <= r_h0_valid;
            r_h1_rd    <= r_h0_rd;
            r_h0_valid <= w_issue;
            r_h0_rd    <= w_rd;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_func        <= NOP_FUNC;
            r_rs1         <= NOP_REG;
            r_rs2         <= NOP_REG;
            r_rd          <= NOP_REG;
            r_addr        <= NOP_ADDR;
            r_issue_valid <= 1'b0;
            r_issue_cnt   <= '0;
            r_stall_cnt   <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_issue) begin
                r_func        <= w_func;
                r_rs1         <= w_rs1;
                r_rs2         <= w_rs2;
                r_rd          <= w_rd;
                r_addr        <= w_addr;
                r_issue_valid <= 1'b1;
                if (r_issue_cnt != 16'hFFFF) r_issue_cnt <= r_issue_cnt + 16'd1;
            end else begin
                r_func        <= NOP_FUNC;
                r_rs1         <= NOP_REG;
                r_rs2         <= NOP_REG;
                r_rd          <= NOP_REG;
                r_addr        <= NOP_ADDR;
                r_issue_valid <= 1'b0;
            end
            if (w_active && w_hazard && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_pop && w_illegal) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

    assign in_ready    = !w_full;
    assign fifo_level  = r_level;
    assign func        = r_func;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign addr        = r_addr;
    assign issue_valid = r_issue_valid;
    assign issue_cnt   = r_issue_cnt;
    assign stall_cnt   = r_stall_cnt;
    assign err_illegal = r_err_illegal;
endmodule

// File: tb/tb_pipe_issue.sv
// Directed self-checking bench for pipe_issue: each step drives one clock edge
// and the following checks compare registered outputs with hand-computed values.
module tb_pipe_issue;
    logic        clk1;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_instr;
    logic        in_ready;
    logic        run;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic        issue_valid;
    logic [2:0]  fifo_level;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;
    logic        err_illegal;

    int passCount  = 0;
    int checkCount = 0;

    pipe_issue dut (
        .clk1        (clk1),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .run         (run),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .issue_valid (issue_valid),
        .fifo_level  (fifo_level),
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt),
        .err_illegal (err_illegal)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [7:0] a);
        return {f, d, s1, s2, a};
    endfunction

    // Inputs settle 1 time unit after an edge, so outputs are read well away from it.
    task automatic applyStimulus(input logic v, input logic [23:0] instr, input logic r);
        in_valid = v;
        in_instr = instr;
        run      = r;
        @(posedge clk1);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, " valid"}, 32'(issue_valid), 32'd0);
        checkOutput({tag, " func"},  32'(func),        32'd3);
        checkOutput({tag, " rd"},    32'(rd),          32'd15);
        checkOutput({tag, " rs1"},   32'(rs1),         32'd15);
        checkOutput({tag, " addr"},  32'(addr),        32'hFF);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 24'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        run      = 1'b0;
        @(posedge clk1);
        #1;

        // Reset state
        doReset();
        checkBubble("reset");
        checkOutput("reset level", 32'(fifo_level),  32'd0);
        checkOutput("reset ready", 32'(in_ready),    32'd1);
        checkOutput("reset icnt",  32'(issue_cnt),   32'd0);
        checkOutput("reset scnt",  32'(stall_cnt),   32'd0);
        checkOutput("reset err",   32'(err_illegal), 32'd0);

        // Three independent adds issue back to back
        applyStimulus(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h10), 1'b1);
        checkOutput("indep first latency", 32'(issue_valid), 32'd0);
        checkOutput("indep level1", 32'(fifo_level), 32'd1);
        applyStimulus(1'b1, mk(4'd0, 4'd4, 4'd5, 4'd6, 8'h11), 1'b1);
        checkOutput("indep A valid", 32'(issue_valid), 32'd1);
        checkOutput("indep A rd",    32'(rd),   32'd1);
        checkOutput("indep A rs1",   32'(rs1),  32'd2);
        checkOutput("indep A rs2",   32'(rs2),  32'd3);
        checkOutput("indep A func",  32'(func), 32'd0);
        checkOutput("indep A addr",  32'(addr), 32'h10);
        applyStimulus(1'b1, mk(4'd0, 4'd7, 4'd8, 4'd9, 8'h12), 1'b1);
        checkOutput("indep B valid", 32'(issue_valid), 32'd1);
        checkOutput("indep B rd",    32'(rd), 32'd4);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("indep C valid", 32'(issue_valid), 32'd1);
        checkOutput("indep C rd",    32'(rd), 32'd7);
        checkOutput("indep icnt",    32'(issue_cnt), 32'd3);
        checkOutput("indep scnt",    32'(stall_cnt), 32'd0);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("indep drained valid", 32'(issue_valid), 32'd0);
        checkOutput("indep drained level", 32'(fifo_level), 32'd0);

        // RAW hazard: r4 = r1 - r5 waits two bubbles behind r1 = r2 + r3
        doReset();
        applyStimulus(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h20), 1'b1);
        applyStimulus(1'b1, mk(4'd1, 4'd4, 4'd1, 4'd5, 8'h21), 1'b1);
        checkOutput("raw prod valid", 32'(issue_valid), 32'd1);
        checkOutput("raw prod rd",    32'(rd), 32'd1);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkBubble("raw bubble1");
        checkOutput("raw scnt1", 32'(stall_cnt), 32'd1);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkBubble("raw bubble2");
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("raw cons valid", 32'(issue_valid), 32'd1);
        checkOutput("raw cons rd",    32'(rd),   32'd4);
        checkOutput("raw cons func",  32'(func), 32'd1);
        checkOutput("raw scnt",       32'(stall_cnt), 32'd2);
        checkOutput("raw icnt",       32'(issue_cnt), 32'd2);

        // func 4 reads only rs2, so rs1 matching the producer is not a hazard
        doReset();
        applyStimulus(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h30), 1'b1);
        applyStimulus(1'b1, mk(4'd4, 4'd8, 4'd1, 4'd6, 8'h31), 1'b1);
        checkOutput("single prod rd", 32'(rd), 32'd1);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("single cons valid", 32'(issue_valid), 32'd1);
        checkOutput("single cons rd",    32'(rd),   32'd8);
        checkOutput("single cons func",  32'(func), 32'd4);
        checkOutput("single scnt",       32'(stall_cnt), 32'd0);

        // Fill with run low, overflow is refused, then drain and wrap
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, mk(4'd0, 4'(k + 1), 4'd10, 4'd11, 8'(8'h40 + k)), 1'b0);
        end
        checkOutput("full ready", 32'(in_ready),   32'd0);
        checkOutput("full level", 32'(fifo_level), 32'd4);
        checkOutput("full frozen valid", 32'(issue_valid), 32'd0);
        applyStimulus(1'b1, mk(4'd0, 4'd12, 4'd10, 4'd11, 8'h4F), 1'b0);
        checkOutput("full 5th level", 32'(fifo_level), 32'd4);
        applyStimulus(1'b1, mk(4'd0, 4'd12, 4'd10, 4'd11, 8'h4F), 1'b1);
        checkOutput("full pop push-ignored level", 32'(fifo_level), 32'd3);
        checkOutput("full drain rd1", 32'(rd), 32'd1);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b0, 24'd0, 1'b1);
            checkOutput("full drain rd",   32'(rd),   32'(k + 1));
            checkOutput("full drain addr", 32'(addr), 32'(8'h40 + k));
        end
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("full no 5th valid", 32'(issue_valid), 32'd0);
        checkOutput("full empty level",  32'(fifo_level), 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, mk(4'd0, 4'(k + 5), 4'd10, 4'd11, 8'(8'h50 + k)), 1'b0);
        end
        checkOutput("wrap level", 32'(fifo_level), 32'd4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 24'd0, 1'b1);
            checkOutput("wrap rd",   32'(rd),   32'(k + 5));
            checkOutput("wrap addr", 32'(addr), 32'(8'h50 + k));
        end
        checkOutput("wrap icnt", 32'(issue_cnt), 32'd8);

        // Illegal func is discarded as a bubble and latches the error flag
        doReset();
        applyStimulus(1'b1, mk(4'd13, 4'd2, 4'd3, 4'd4, 8'h60), 1'b1);
        applyStimulus(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h61), 1'b1);
        checkBubble("illegal bubble");
        checkOutput("illegal err",  32'(err_illegal), 32'd1);
        checkOutput("illegal icnt0", 32'(issue_cnt), 32'd0);
        checkOutput("illegal scnt0", 32'(stall_cnt), 32'd0);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("illegal next valid", 32'(issue_valid), 32'd1);
        checkOutput("illegal next rd",    32'(rd), 32'd1);
        applyStimulus(1'b0, 24'd0, 1'b1);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("illegal sticky", 32'(err_illegal), 32'd1);
        checkOutput("illegal icnt",   32'(issue_cnt), 32'd1);
        doReset();
        checkOutput("illegal cleared", 32'(err_illegal), 32'd0);

        // Reset with entries queued behind a pending hazard
        applyStimulus(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h70), 1'b1);
        applyStimulus(1'b1, mk(4'd0, 4'd4, 4'd1, 4'd5, 8'h71), 1'b1);
        applyStimulus(1'b1, mk(4'd0, 4'd7, 4'd10, 4'd11, 8'h72), 1'b1);
        applyStimulus(1'b1, mk(4'd0, 4'd8, 4'd10, 4'd11, 8'h73), 1'b1);
        checkOutput("mid level3", 32'(fifo_level), 32'd3);
        checkOutput("mid scnt2",  32'(stall_cnt),  32'd2);
        rst = 1'b1;
        applyStimulus(1'b0, 24'd0, 1'b1);
        rst = 1'b0;
        checkBubble("mid reset");
        checkOutput("mid reset level", 32'(fifo_level), 32'd0);
        checkOutput("mid reset icnt",  32'(issue_cnt),  32'd0);
        checkOutput("mid reset scnt",  32'(stall_cnt),  32'd0);
        applyStimulus(1'b1, mk(4'd0, 4'd9, 4'd1, 4'd4, 8'h74), 1'b1);
        applyStimulus(1'b0, 24'd0, 1'b1);
        checkOutput("mid new valid", 32'(issue_valid), 32'd1);
        checkOutput("mid new rd",    32'(rd), 32'd9);
        checkOutput("mid new scnt",  32'(stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
